// File: rtl/pi_bus_master_pkg.sv
// Shared definitions for the Pi-side RAM bus master: default widths and FSM states.
package pi_bus_pkg;
   localparam int AW_DEF    = 17;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;
endpackage

// File: rtl/pi_bus_master_if.sv
// Bundle of slot-timing, request/response and RAM-side signals of the Pi bus master.
interface pi_bus_master_if
   import pi_bus_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          pi_select;
   logic          pi_strobe;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          rsp_valid;
   logic          rsp_we;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] ram_din;
   logic          bus_oe;
   logic          ram_we;
   logic          ram_oe;

   modport master (
      input  pi_select, pi_strobe, req_valid, req_we, req_addr, req_data, ram_din,
      output req_ready, rsp_valid, rsp_we, rsp_data, ram_addr, ram_dout, bus_oe, ram_we, ram_oe
   );

   modport slave (
      output pi_select, pi_strobe, req_valid, req_we, req_addr, req_data, ram_din,
      input  req_ready, rsp_valid, rsp_we, rsp_data, ram_addr, ram_dout, bus_oe, ram_we, ram_oe
   );
endinterface

// File: rtl/pi_bus_master_fifo.sv
// Small synchronous request queue; head is visible combinationally, pushes ignored when full.
module sync_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [PW:0]      cnt_q;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= din_i;
   end

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop_ok)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
      end
   end
endmodule

// File: rtl/pi_bus_master.sv
// Executes queued RAM requests, one per pi_select window, with bus drives gated by the
// window/strobe so nothing reaches the RAM bus outside the Pi slot.
module pi_bus_master
   import pi_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = AW_DEF,
   parameter int DATA_WIDTH = DW_DEF,
   parameter int FIFO_DEPTH = DEPTH_DEF
) (
   input  logic            clk16_i,
   input  logic            reset_i,
   pi_bus_master_if.master bus_if
);
   localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;

   logic                  sel_q, stb_q;
   logic                  sel_rise, sel_fall, stb_fall;
   state_e                state_q, state_d;
   logic                  active_q, active_d, retry_q, retry_d;
   logic                  cur_we_q, cur_we_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [DATA_WIDTH-1:0] cur_data_q, cur_data_d;
   logic                  rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  fifo_pop, fifo_full, fifo_empty;
   logic [FW-1:0]         fifo_head;

   sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk16_i),
      .rst_i   (reset_i),
      .push_i  (bus_if.req_valid),
      .pop_i   (fifo_pop),
      .din_i   ({bus_if.req_we, bus_if.req_addr, bus_if.req_data}),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign sel_rise = bus_if.pi_select & ~sel_q;
   assign sel_fall = ~bus_if.pi_select & sel_q;
   assign stb_fall = ~bus_if.pi_strobe & stb_q;

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      retry_d     = retry_q;
      cur_we_d    = cur_we_q;
      cur_addr_d  = cur_addr_q;
      cur_data_d  = cur_data_q;
      rsp_valid_d = 1'b0;
      rsp_we_d    = rsp_we_q;
      rsp_data_d  = rsp_data_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A window missed without a strobe leaves its request in cur; it goes first.
            if (sel_rise && retry_q) begin
               active_d = 1'b1;
               state_d  = ST_ADDR;
            end else if (sel_rise && !fifo_empty) begin
               fifo_pop = 1'b1;
               {cur_we_d, cur_addr_d, cur_data_d} = fifo_head;
               active_d = 1'b1;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (bus_if.pi_strobe) begin
               state_d = ST_STROBE;
            end else if (sel_fall) begin
               active_d = 1'b0;
               retry_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_STROBE: begin
            if (stb_fall) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = cur_we_q;
               rsp_data_d  = cur_we_q ? cur_data_q : bus_if.ram_din;
               retry_d     = 1'b0;
               active_d    = ~sel_fall;
               state_d     = sel_fall ? ST_IDLE : ST_HOLD;
            end else if (sel_fall) begin
               active_d = 1'b0;
               retry_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (sel_fall) begin
               active_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk16_i) begin
      if (reset_i) begin
         sel_q       <= 1'b0;
         stb_q       <= 1'b0;
         state_q     <= ST_IDLE;
         active_q    <= 1'b0;
         retry_q     <= 1'b0;
         cur_we_q    <= 1'b0;
         cur_addr_q  <= '0;
         cur_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         sel_q       <= bus_if.pi_select;
         stb_q       <= bus_if.pi_strobe;
         state_q     <= state_d;
         active_q    <= active_d;
         retry_q     <= retry_d;
         cur_we_q    <= cur_we_d;
         cur_addr_q  <= cur_addr_d;
         cur_data_q  <= cur_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Reset term kills the drives in the very cycle reset is raised.
   assign bus_if.bus_oe    = bus_if.pi_select & active_q & ~reset_i;
   assign bus_if.ram_we    = bus_if.pi_strobe & active_q & cur_we_q & ~reset_i;
   assign bus_if.ram_oe    = bus_if.pi_select & active_q & ~cur_we_q & ~reset_i;
   assign bus_if.ram_addr  = cur_addr_q;
   assign bus_if.ram_dout  = cur_data_q;
   assign bus_if.req_ready = ~fifo_full;
   assign bus_if.rsp_valid = rsp_valid_q;
   assign bus_if.rsp_we    = rsp_we_q;
   assign bus_if.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_pi_bus_master.sv
// Bench for pi_bus_master: slot generator, 128K x 8 RAM, in-order response model.
module tb_pi_bus_master;
   typedef struct {logic we; logic [7:0] d;} exp_t;
   typedef struct {logic we; logic [7:0] d; int cyc; int ph;} got_t;

   logic clk16 = 1'b0;
   logic reset;
   pi_bus_master_if #(.AW(17), .DW(8)) bif ();

   pi_bus_master dut (
      .clk16_i (clk16),
      .reset_i (reset),
      .bus_if  (bif.master)
   );

   logic [7:0]  ram [0:131071];
   logic [7:0]  mdl [0:131071];
   exp_t        exp_q[$];
   got_t        got_q[$];
   int          gi = 0;
   int          checks = 0, errors = 0;
   int          ph = 15, cyc = 0;
   logic        skip_stb = 1'b0;
   int          we_cnt = 0, oe_cnt = 0, viol = 0, pulse_err = 0;
   logic [16:0] we_addr = '0;
   logic        rsp_prev = 1'b0;
   int          acc_cyc = 0, acc_ph = 0;

   initial forever #5 clk16 = ~clk16;

   assign bif.ram_din = ram[bif.ram_addr];

   // RAM model: zero at start, written on each clock with ram_we high.
   initial begin
      for (int i = 0; i < 131072; i++) begin ram[i] = 8'h00; mdl[i] = 8'h00; end
      forever begin
         @(posedge clk16);
         if (bif.ram_we) ram[bif.ram_addr] = bif.ram_dout;
      end
   end

   // Slot timing: 16-clock frame, select for phases 0..7, strobe on phases 3..4.
   initial begin
      bif.pi_select = 1'b0;
      bif.pi_strobe = 1'b0;
      forever begin
         @(posedge clk16); #1;
         cyc++;
         ph = (ph + 1) % 16;
         bif.pi_select = (ph < 8);
         bif.pi_strobe = !skip_stb && (ph == 3 || ph == 4);
      end
   end

   initial forever begin
      @(negedge clk16);
      if (bif.rsp_valid) begin
         got_q.push_back('{bif.rsp_we, bif.rsp_data, cyc, ph});
         if (rsp_prev) pulse_err++;
      end
      rsp_prev = bif.rsp_valid;
      if (bif.ram_we) begin we_cnt++; we_addr = bif.ram_addr; end
      if (bif.ram_oe) oe_cnt++;
      if ((bif.bus_oe || bif.ram_we || bif.ram_oe) && !bif.pi_select) viol++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic wait_ph(input int t);
      int k = 0;
      @(negedge clk16);
      while (ph != (t + 15) % 16 && k < 40) begin @(negedge clk16); k++; end
      @(posedge clk16); #1;
   endtask

   task automatic wait_rsp(input int n);
      int k = 0;
      while (got_q.size() - gi < n && k < 16 * n + 64) begin @(negedge clk16); k++; end
   endtask

   task automatic push(input logic we, input logic [16:0] a, input logic [7:0] d, input bit model);
      int n = 0;
      bif.req_valid = 1'b1; bif.req_we = we; bif.req_addr = a; bif.req_data = d;
      @(negedge clk16);
      while (!bif.req_ready && n < 100) begin @(negedge clk16); n++; end
      checks++;
      if (!bif.req_ready) begin
         errors++; $display("FAIL push_timeout ready=%0b want 1", bif.req_ready);
      end else begin
         acc_cyc = cyc; acc_ph = ph;
         if (model) begin
            if (we) begin mdl[a] = d; exp_q.push_back('{1'b1, d}); end
            else exp_q.push_back('{1'b0, mdl[a]});
         end
      end
      @(posedge clk16); #1;
      bif.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      int k = 0;
      reset = 1'b1;
      bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0; bif.req_data = '0;
      repeat (3) @(negedge clk16);
      while (ph != 2 && k < 40) begin @(negedge clk16); k++; end
      checks++; if (bif.bus_oe !== 1'b0) begin errors++; $display("FAIL reset_bus_oe got=%0b want=0", bif.bus_oe); end
      checks++; if (bif.ram_oe !== 1'b0) begin errors++; $display("FAIL reset_ram_oe got=%0b want=0", bif.ram_oe); end
      @(posedge clk16); #1; reset = 1'b0;
      @(negedge clk16);
      checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", bif.req_ready); end
      checks++; if (bif.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b want=0", bif.rsp_valid); end
      checks++; if (bif.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got=%h want=00", bif.rsp_data); end
      checks++; if (bif.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%0b want=0", bif.ram_we); end
   endtask

   task automatic test_write();
      int w0; int n0; got_t g; exp_t e;
      wait_ph(10);
      w0 = we_cnt; n0 = got_q.size();
      push(1'b1, 17'h1234, 8'hA5, 1'b1);
      wait_rsp(1);
      repeat (16) @(negedge clk16);
      checks++; if (got_q.size() - n0 != 1) begin errors++; $display("FAIL wr_rsp_count got=%0d want=1", got_q.size() - n0); end
      if (got_q.size() > gi) begin
         g = got_q[gi]; gi = got_q.size(); e = exp_q.pop_front();
         checks++; if (g.we !== e.we || g.d !== e.d) begin errors++; $display("FAIL wr_rsp we/data got=%0b/%h want=%0b/%h", g.we, g.d, e.we, e.d); end
         checks++; if (g.ph != 6) begin errors++; $display("FAIL wr_rsp_phase got=%0d want=6", g.ph); end
      end
      checks++; if (we_cnt - w0 != 2) begin errors++; $display("FAIL wr_we_cycles got=%0d want=2", we_cnt - w0); end
      checks++; if (we_addr !== 17'h1234) begin errors++; $display("FAIL wr_addr got=%h want=1234", we_addr); end
      checks++; if (ram[17'h1234] !== 8'hA5) begin errors++; $display("FAIL wr_ram got=%h want=a5", ram[17'h1234]); end
   endtask

   task automatic test_read();
      int o0, w0; got_t g; exp_t e;
      wait_ph(10);
      o0 = oe_cnt; w0 = we_cnt;
      push(1'b0, 17'h1234, 8'h00, 1'b1);
      wait_rsp(1);
      repeat (12) @(negedge clk16);
      if (got_q.size() > gi) begin
         g = got_q[gi]; gi++; e = exp_q.pop_front();
         checks++; if (g.we !== e.we || g.d !== e.d) begin errors++; $display("FAIL rd_rsp we/data got=%0b/%h want=%0b/%h", g.we, g.d, e.we, e.d); end
         checks++; if (g.ph != 6) begin errors++; $display("FAIL rd_rsp_phase got=%0d want=6", g.ph); end
      end else begin
         checks++; errors++; $display("FAIL rd_rsp missing got=0 want=1");
      end
      checks++; if (oe_cnt - o0 != 7) begin errors++; $display("FAIL rd_oe_cycles got=%0d want=7", oe_cnt - o0); end
      checks++; if (we_cnt != w0) begin errors++; $display("FAIL rd_we_cycles got=%0d want=0", we_cnt - w0); end
   endtask

   task automatic test_back_to_back();
      int pc; got_t g; exp_t e;
      wait_ph(10);
      for (int i = 0; i < 2; i++)
         push(1'($urandom_range(0, 1)), 17'($urandom_range(16'h100, 16'h10F)), 8'($urandom), 1'b1);
      @(negedge clk16);
      checks++; if (bif.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%0b want=0", bif.req_ready); end
      push(1'($urandom_range(0, 1)), 17'($urandom_range(16'h100, 16'h10F)), 8'($urandom), 1'b1);
      checks++; if (acc_ph != 1) begin errors++; $display("FAIL b2b_third_accept_phase got=%0d want=1", acc_ph); end
      wait_rsp(3);
      pc = -1;
      for (int i = 0; i < 3; i++) begin
         if (got_q.size() > gi && exp_q.size() > 0) begin
            g = got_q[gi]; gi++; e = exp_q.pop_front();
            checks++; if (g.we !== e.we || g.d !== e.d) begin errors++; $display("FAIL b2b_rsp%0d we/data got=%0b/%h want=%0b/%h", i, g.we, g.d, e.we, e.d); end
            if (pc >= 0) begin
               checks++; if (g.cyc - pc != 16) begin errors++; $display("FAIL b2b_spacing%0d got=%0d want=16", i, g.cyc - pc); end
            end
            pc = g.cyc;
         end else begin
            checks++; errors++; $display("FAIL b2b_rsp%0d missing", i);
         end
      end
   endtask

   task automatic test_sel_rise_push();
      got_t g; exp_t e;
      wait_ph(0);
      push(1'b1, 17'h0105, 8'($urandom), 1'b1);
      checks++; if (acc_ph != 0) begin errors++; $display("FAIL rise_accept_phase got=%0d want=0", acc_ph); end
      wait_rsp(1);
      if (got_q.size() > gi) begin
         g = got_q[gi]; gi++; e = exp_q.pop_front();
         checks++; if (g.cyc - acc_cyc != 22) begin errors++; $display("FAIL rise_latency got=%0d want=22", g.cyc - acc_cyc); end
         checks++; if (g.we !== e.we || g.d !== e.d) begin errors++; $display("FAIL rise_rsp we/data got=%0b/%h want=%0b/%h", g.we, g.d, e.we, e.d); end
      end else begin
         checks++; errors++; $display("FAIL rise_rsp missing");
      end
   endtask

   task automatic test_retry();
      int a0, o0; got_t g; exp_t e;
      wait_ph(10);
      o0 = oe_cnt;
      push(1'b0, 17'h0101, 8'h00, 1'b1);
      a0 = acc_cyc;
      push(1'b1, 17'h0101, 8'($urandom), 1'b1);
      skip_stb = 1'b1;
      wait_ph(10);
      skip_stb = 1'b0;
      wait_rsp(2);
      if (got_q.size() - gi >= 2) begin
         g = got_q[gi]; gi++; e = exp_q.pop_front();
         checks++; if (g.cyc - a0 != 28) begin errors++; $display("FAIL retry_latency got=%0d want=28", g.cyc - a0); end
         checks++; if (g.we !== e.we || g.d !== e.d) begin errors++; $display("FAIL retry_rsp0 we/data got=%0b/%h want=%0b/%h", g.we, g.d, e.we, e.d); end
         a0 = g.cyc;
         g = got_q[gi]; gi++; e = exp_q.pop_front();
         checks++; if (g.cyc - a0 != 16) begin errors++; $display("FAIL retry_spacing got=%0d want=16", g.cyc - a0); end
         checks++; if (g.we !== e.we || g.d !== e.d) begin errors++; $display("FAIL retry_rsp1 we/data got=%0b/%h want=%0b/%h", g.we, g.d, e.we, e.d); end
      end else begin
         checks++; errors++; $display("FAIL retry_rsp count got=%0d want=2", got_q.size() - gi);
      end
      checks++; if (oe_cnt - o0 != 14) begin errors++; $display("FAIL retry_oe_cycles got=%0d want=14", oe_cnt - o0); end
   endtask

   task automatic test_random();
      got_t g; exp_t e;
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 20)) begin @(posedge clk16); #1; end
         push(1'($urandom_range(0, 1)), 17'($urandom_range(16'h100, 16'h10F)), 8'($urandom), 1'b1);
      end
      wait_rsp(exp_q.size());
      while (got_q.size() > gi && exp_q.size() > 0) begin
         g = got_q[gi]; gi++; e = exp_q.pop_front();
         checks++; if (g.we !== e.we || g.d !== e.d || g.ph != 6) begin
            errors++; $display("FAIL rand_rsp%0d we/data/phase got=%0b/%h/%0d want=%0b/%h/6", gi, g.we, g.d, g.ph, e.we, e.d);
         end
      end
      checks++; if (exp_q.size() != 0 || got_q.size() != gi) begin
         errors++; $display("FAIL rand_leftover missing=%0d extra=%0d want=0/0", exp_q.size(), got_q.size() - gi);
      end
   endtask

   task automatic test_reset_mid_strobe();
      int n0; int k = 0; got_t g; exp_t e;
      wait_ph(10);
      push(1'b1, 17'h1FFFF, 8'h3C, 1'b0);
      push(1'b1, 17'h1FFFE, 8'h5A, 1'b0);
      n0 = got_q.size();
      @(negedge clk16);
      while (ph != 3 && k < 40) begin @(negedge clk16); k++; end
      @(posedge clk16); #1; reset = 1'b1;
      @(negedge clk16);
      checks++; if (bif.ram_we !== 1'b0) begin errors++; $display("FAIL rst_strobe_ram_we got=%0b want=0", bif.ram_we); end
      checks++; if (bif.bus_oe !== 1'b0) begin errors++; $display("FAIL rst_strobe_bus_oe got=%0b want=0", bif.bus_oe); end
      @(posedge clk16); #1; reset = 1'b0;
      @(negedge clk16);
      checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL rst_strobe_ready got=%0b want=1", bif.req_ready); end
      repeat (40) @(negedge clk16);
      checks++; if (got_q.size() != n0) begin errors++; $display("FAIL rst_strobe_rsp got=%0d want=0", got_q.size() - n0); end
      checks++; if (ram[17'h1FFFE] !== 8'h00) begin errors++; $display("FAIL rst_fifo_flush ram=%h want=00", ram[17'h1FFFE]); end
      gi = got_q.size();
      wait_ph(10);
      push(1'b0, 17'h1234, 8'h00, 1'b1);
      wait_rsp(1);
      if (got_q.size() > gi) begin
         g = got_q[gi]; gi++; e = exp_q.pop_front();
         checks++; if (g.we !== e.we || g.d !== e.d) begin errors++; $display("FAIL rst_recover we/data got=%0b/%h want=%0b/%h", g.we, g.d, e.we, e.d); end
      end else begin
         checks++; errors++; $display("FAIL rst_recover missing");
      end
   endtask

   task automatic test_safety();
      checks++; if (viol != 0) begin errors++; $display("FAIL window_safety violations=%0d want=0", viol); end
      checks++; if (pulse_err != 0) begin errors++; $display("FAIL rsp_pulse_width long_pulses=%0d want=0", pulse_err); end
   endtask

   initial begin
      reset = 1'b1;
      bif.req_valid = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_sel_rise_push();
      test_retry();
      test_random();
      test_reset_mid_strobe();
      test_safety();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
